axil_regbank: RTL and testbench

- Parametrised AXI4-Lite slave register bank. It generalises the fixed four-register, 32-bit slave used in the vm_agent_shim example to N registers of configurable width.
- Adds byte strobes, per-register read-only and write-1-to-clear modes, a per-register write pulse, and SLVERR on illegal accesses.
- Sits behind the BFM master in block designs and exposes flat register outputs and hardware-input buses to user logic.

---
 rtl/axil_regbank_if.sv | 41 ++++
 rtl/axil_regbank.sv | 191 +++++++++++++++++++
 tb/tb_axil_regbank.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_regbank_if.sv
// rtl/axil_regbank_if.sv - AXI4-Lite bus bundle between a master and the register bank slave
interface axil_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_regbank.sv
// rtl/axil_regbank.sv - AXI4-Lite register bank with byte strobes, RO/W1C registers and write pulses
module axil_regbank #(
  parameter int                         DATA_W   = 32,
  parameter int                         ADDR_W   = 8,
  parameter int                         NUM_REGS = 16,
  parameter logic [63:0]                RO_MASK  = '0,
  parameter logic [63:0]                W1C_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  axil_regbank_if.slave                s_axi,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
  output logic [NUM_REGS-1:0]          wr_pulse
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e            w_state_q;
  logic                aw_held_q, w_held_q;
  logic                awready_q, wready_q, bvalid_q;
  logic [1:0]          bresp_q;
  logic [IDX_W-1:0]    aw_idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [NUM_REGS-1:0] wr_pulse_q;

  r_state_e            r_state_q;
  logic                arready_q, rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;

  logic                aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
  logic [IDX_W-1:0]    ar_idx;
  logic [NUM_REGS-1:0] aw_sel, ar_sel, wr_hit;
  logic [DATA_W-1:0]   byte_mask, rd_word;
  logic                unused_bits;

  assign aw_hs  = s_axi.awvalid && awready_q;
  assign w_hs   = s_axi.wvalid && wready_q;
  assign ar_hs  = s_axi.arvalid && arready_q;
  assign ar_idx = s_axi.araddr[ADDR_W-1:LSB];
  assign commit = (w_state_q != W_RESP) && aw_held_q && w_held_q;

  always_comb begin
    aw_sel = '0;
    ar_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx_q == IDX_W'(i)) aw_sel[i] = 1'b1;
      if (ar_idx == IDX_W'(i))   ar_sel[i] = 1'b1;
    end
  end

  // An index with no matching select bit is out of range.
  assign wr_err = !(|aw_sel) || |(aw_sel & RO_MASK[NUM_REGS-1:0]);
  assign rd_err = !(|ar_sel);
  assign wr_hit = {NUM_REGS{commit && !wr_err}} & aw_sel;

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_W; b++) byte_mask[b*8 +: 8] = {8{wstrb_q[b]}};
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_sel[i]) rd_word = reg_out[i*DATA_W +: DATA_W];
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_out[i*DATA_W +: DATA_W] = hw_in[i*DATA_W +: DATA_W];
    end else begin : g_rw
      logic [DATA_W-1:0] reg_q;
      // For W1C the hardware set is OR-ed in after the clear, so set wins.
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
          reg_q <= W1C_MASK[i] ? '0 : RST_VAL[i*DATA_W +: DATA_W];
        else if (W1C_MASK[i])
          reg_q <= (reg_q & ~(wdata_q & byte_mask & {DATA_W{wr_hit[i]}}))
                   | hw_set[i*DATA_W +: DATA_W];
        else if (wr_hit[i])
          reg_q <= (reg_q & ~byte_mask) | (wdata_q & byte_mask);
      end
      assign reg_out[i*DATA_W +: DATA_W] = reg_q;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      case (w_state_q)
        W_IDLE, W_COLLECT: begin
          if (aw_held_q && w_held_q) begin
            w_state_q  <= W_RESP;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_err ? 2'b10 : 2'b00;
            wr_pulse_q <= wr_hit;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              aw_idx_q  <= s_axi.awaddr[ADDR_W-1:LSB];
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              wdata_q  <= s_axi.wdata;
              wstrb_q  <= s_axi.wstrb;
            end
            awready_q <= !(aw_held_q || aw_hs);
            wready_q  <= !(w_held_q || w_hs);
            w_state_q <= (aw_held_q || aw_hs || w_held_q || w_hs) ? W_COLLECT : W_IDLE;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_err ? '0 : rd_word;
            rresp_q   <= rd_err ? 2'b10 : 2'b00;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign wr_pulse      = wr_pulse_q;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[LSB-1:0],
                         s_axi.araddr[LSB-1:0], hw_in, hw_set};
endmodule

// File: tb/tb_axil_regbank.sv
// tb/tb_axil_regbank.sv - randomized self-checking bench for axil_regbank against a register-map model
module tb_axil_regbank;
  localparam int NR = 16;
  localparam logic [NR*32-1:0] RST_IMG = (512'hA5A5_0000)
                                       | (512'h1111_1111 << 32)
                                       | (512'h0000_1234 << 64)
                                       | (512'hFFFF_FFFF << 96)
                                       | (512'hCAFE_0005 << 160);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*32-1:0] reg_out, hw_in, hw_set;
  logic [NR-1:0]   wr_pulse;
  logic [31:0]     model [NR];
  logic [31:0]     hw1;
  int              checks = 0;
  int              failures = 0;
  int              pulse_total = 0;

  axil_regbank_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  axil_regbank #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(NR),
    .RO_MASK(64'h2), .W1C_MASK(64'h8), .RST_VAL(RST_IMG)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(bus.slave),
    .reg_out(reg_out), .hw_in(hw_in), .hw_set(hw_set), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) pulse_total += $countones(wr_pulse);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: register map described by reset words, RO slot 1, W1C slot 3.
  function automatic logic [31:0] rst_word(int i);
    case (i)
      0:       return 32'hA5A5_0000;
      2:       return 32'h0000_1234;
      5:       return 32'hCAFE_0005;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) model[i] = rst_word(i);
  endfunction

  function automatic logic [31:0] exp_rd(int idx);
    if (idx >= NR) return 32'h0;
    if (idx == 1) return hw1;
    return model[idx];
  endfunction

  function automatic logic [1:0] model_write(logic [7:0] addr, logic [31:0] data, logic [3:0] strb);
    int idx;
    logic [31:0] m;
    idx = int'(addr) / 4;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) m[b*8 +: 8] = 8'hFF;
    if (idx >= NR || idx == 1) return 2'b10;
    if (idx == 3) model[3] = model[3] & ~(data & m);
    else model[idx] = (model[idx] & ~m) | (data & m);
    return 2'b00;
  endfunction

  task automatic set_hw1(input logic [31:0] v);
    hw1 = v;
    hw_in[63:32] = v;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input int b_hold, output logic [1:0] resp,
                          output logic [NR-1:0] pulse_at_b, output bit stable, output bit tmo);
    int aw_start, w_start, cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    tmo = 0; stable = 1; resp = 2'b00; pulse_at_b = '0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb; bus.bready = 1'b0;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= aw_start);
      bus.wvalid  = !w_done && (cyc >= w_start);
      @(negedge clk);
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (!(aw_done && w_done)) begin tmo = 1; return; end
    cyc = 0;
    @(negedge clk);
    while (!bus.bvalid) begin
      if (cyc++ > 20) begin tmo = 1; return; end
      @(negedge clk);
    end
    resp = bus.bresp;
    pulse_at_b = wr_pulse;
    if (b_hold < 0) begin @(posedge clk); #1; return; end
    for (int k = 0; k < b_hold; k++) begin
      @(negedge clk);
      if (!bus.bvalid || bus.bresp !== resp || wr_pulse !== '0) stable = 0;
    end
    @(posedge clk); #1; bus.bready = 1'b1;
    @(posedge clk); #1; bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, input int r_hold, output logic [31:0] data,
                         output logic [1:0] resp, output bit stable, output bit tmo);
    int cyc;
    tmo = 0; stable = 1; data = '0; resp = 2'b00; cyc = 0;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge clk);
    while (!bus.arready) begin
      if (cyc++ > 20) begin tmo = 1; bus.arvalid = 1'b0; return; end
      @(negedge clk);
    end
    @(posedge clk); #1; bus.arvalid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!bus.rvalid) begin
      if (cyc++ > 20) begin tmo = 1; return; end
      @(negedge clk);
    end
    data = bus.rdata; resp = bus.rresp;
    for (int k = 0; k < r_hold; k++) begin
      @(negedge clk);
      if (!bus.rvalid || bus.rdata !== data || bus.rresp !== resp) stable = 0;
    end
    @(posedge clk); #1; bus.rready = 1'b1;
    @(posedge clk); #1; bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit st, tmo;
    @(negedge clk);
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0 ||
        bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.rdata !== 32'h0 || wr_pulse !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready/valid=%b bresp=%b rresp=%b rdata=%h pulse=%h required all zero",
               {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, bus.bresp, bus.rresp,
               bus.rdata, wr_pulse);
    end
    checks++;
    if (reg_out[31:0] !== 32'hA5A5_0000 || reg_out[127:96] !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs: reg0=%h reg3=%h required a5a50000 00000000", reg_out[31:0], reg_out[127:96]);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(8'h00, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== 32'hA5A5_0000 || r !== 2'b00) begin
      failures++;
      $display("FAIL reset_read0: got %h/%b tmo=%0d required a5a50000/00", d, r, tmo);
    end
    do_read(8'h14, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== exp_rd(5) || r !== 2'b00) begin
      failures++;
      $display("FAIL reset_read5: got %h/%b required %h/00", d, r, exp_rd(5));
    end
  endtask

  task automatic test_sequential();
    logic [1:0] r, er; logic [NR-1:0] p; bit st, tmo; logic [31:0] d; int p0;
    for (int i = 0; i < 4; i++) begin
      p0 = pulse_total;
      er = model_write(8'(i*4), 32'(i+1), 4'hF);
      do_write(8'(i*4), 32'(i+1), 4'hF, 0, 0, r, p, st, tmo);
      checks++;
      if (tmo || r !== er) begin
        failures++;
        $display("FAIL seq_bresp[%0d]: got %b tmo=%0d required %b", i, r, tmo, er);
      end
      checks++;
      if (p !== ((er == 2'b00) ? NR'(1 << i) : NR'(0)) || (pulse_total - p0) != ((er == 2'b00) ? 1 : 0)) begin
        failures++;
        $display("FAIL seq_pulse[%0d]: at_b=%h count=%0d", i, p, pulse_total - p0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(8'(i*4), 0, d, r, st, tmo);
      checks++;
      if (tmo || d !== exp_rd(i) || r !== 2'b00) begin
        failures++;
        $display("FAIL seq_read[%0d]: got %h/%b required %h/00", i, d, r, exp_rd(i));
      end
    end
  endtask

  task automatic test_strobe_order();
    logic [1:0] r, er; logic [NR-1:0] p; bit st, tmo; logic [31:0] d; int p0;
    er = model_write(8'h08, 32'h1122_3344, 4'hF);
    do_write(8'h08, 32'h1122_3344, 4'hF, 0, 0, r, p, st, tmo);
    p0 = pulse_total;
    er = model_write(8'h08, 32'hAABB_CCDD, 4'b0101);
    do_write(8'h08, 32'hAABB_CCDD, 4'b0101, 3, 0, r, p, st, tmo);
    checks++;
    if (tmo || r !== er || p !== NR'(1 << 2) || (pulse_total - p0) != 1) begin
      failures++;
      $display("FAIL strb_resp: resp=%b tmo=%0d pulse=%h count=%0d", r, tmo, p, pulse_total - p0);
    end
    @(negedge clk);
    checks++;
    if (bus.bvalid !== 1'b0) begin
      failures++;
      $display("FAIL strb_single_b: bvalid=%b required 0", bus.bvalid);
    end
    @(posedge clk); #1;
    do_read(8'h0A, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== 32'h11BB_33DD || d !== exp_rd(2)) begin
      failures++;
      $display("FAIL strb_value: got %h required 11bb33dd", d);
    end
  endtask

  task automatic test_ro_w1c();
    logic [1:0] r, er; logic [NR-1:0] p; bit st, tmo; logic [31:0] d; int p0;
    set_hw1(32'hDEAD_BEEF);
    p0 = pulse_total;
    er = model_write(8'h04, 32'h1234_5678, 4'hF);
    do_write(8'h04, 32'h1234_5678, 4'hF, -1, 0, r, p, st, tmo);
    checks++;
    if (tmo || r !== 2'b10 || er !== 2'b10 || p !== '0 || pulse_total != p0) begin
      failures++;
      $display("FAIL ro_write: resp=%b pulse=%h required 10 and no pulse", r, p);
    end
    do_read(8'h04, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      failures++;
      $display("FAIL ro_read: got %h/%b required deadbeef/00", d, r);
    end
    er = model_write(8'h0C, 32'hFFFF_FFFF, 4'hF);
    do_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, r, p, st, tmo);
    hw_set[127:96] = 32'hF0;
    @(posedge clk); #1;
    hw_set[127:96] = 32'h0;
    model[3] = model[3] | 32'hF0;
    er = model_write(8'h0C, 32'h30, 4'hF);
    do_write(8'h0C, 32'h30, 4'hF, 0, 0, r, p, st, tmo);
    do_read(8'h0C, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== 32'hC0 || d !== exp_rd(3)) begin
      failures++;
      $display("FAIL w1c_clear: got %h required 000000c0", d);
    end
    er = model_write(8'h0C, 32'h10, 4'hF);
    model[3] = model[3] | 32'h10;
    fork
      do_write(8'h0C, 32'h10, 4'hF, 0, 0, r, p, st, tmo);
      begin
        @(posedge clk); #1; hw_set[127:96] = 32'h10;
        @(posedge clk); #1; hw_set[127:96] = 32'h0;
      end
    join
    do_read(8'h0C, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== 32'hD0 || d !== exp_rd(3)) begin
      failures++;
      $display("FAIL w1c_set_wins: got %h required 000000d0", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r, er; logic [NR-1:0] p; bit st, tmo; logic [31:0] d; int p0;
    p0 = pulse_total;
    er = model_write(8'h40, 32'hFFFF_FFFF, 4'hF);
    do_write(8'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, r, p, st, tmo);
    checks++;
    if (tmo || r !== 2'b10 || er !== 2'b10 || p !== '0 || pulse_total != p0) begin
      failures++;
      $display("FAIL oor_write: resp=%b pulse=%h count=%0d required 10, none", r, p, pulse_total - p0);
    end
    for (int i = 0; i < NR; i++) begin
      if (i == 1) continue;
      checks++;
      if (reg_out[i*32 +: 32] !== model[i]) begin
        failures++;
        $display("FAIL oor_unchanged[%0d]: got %h required %h", i, reg_out[i*32 +: 32], model[i]);
      end
    end
    do_read(8'h40, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== 32'h0 || r !== 2'b10) begin
      failures++;
      $display("FAIL oor_read: got %h/%b required 00000000/10", d, r);
    end
  endtask

  task automatic test_same_edge();
    logic [1:0] r, er, rr; logic [NR-1:0] p; bit st, st2, tmo, tmo2; logic [31:0] d, old;
    old = exp_rd(0);
    er = model_write(8'h00, 32'h5A5A_1234, 4'hF);
    fork
      do_write(8'h00, 32'h5A5A_1234, 4'hF, 0, 0, r, p, st, tmo);
      begin
        @(posedge clk); #1;
        do_read(8'h00, 0, d, rr, st2, tmo2);
      end
    join
    checks++;
    if (tmo || tmo2 || d !== old) begin
      failures++;
      $display("FAIL same_edge_read: got %h required %h", d, old);
    end
    do_read(8'h00, 0, d, rr, st2, tmo2);
    checks++;
    if (tmo2 || d !== exp_rd(0)) begin
      failures++;
      $display("FAIL same_edge_after: got %h required %h", d, exp_rd(0));
    end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [NR-1:0] p; bit st, tmo; logic [31:0] d, data;
    logic [7:0] addr; logic [3:0] strb; int idx, lead, p0;
    for (int n = 0; n < 40; n++) begin
      idx  = $urandom_range(0, NR + 1);
      addr = 8'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) set_hw1($urandom);
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom; strb = 4'($urandom_range(0, 15)); lead = $urandom_range(0, 6) - 3;
        p0 = pulse_total;
        er = model_write(addr, data, strb);
        do_write(addr, data, strb, lead, 0, r, p, st, tmo);
        checks++;
        if (tmo || r !== er || p !== ((er == 2'b00) ? NR'(1 << idx) : NR'(0)) ||
            (pulse_total - p0) != ((er == 2'b00) ? 1 : 0)) begin
          failures++;
          $display("FAIL rand_write[%0d]: addr=%h resp=%b req %b pulse=%h tmo=%0d", n, addr, r, er, p, tmo);
        end
      end else begin
        do_read(addr, 0, d, r, st, tmo);
        checks++;
        if (tmo || d !== exp_rd(idx) || r !== ((idx >= NR) ? 2'b10 : 2'b00)) begin
          failures++;
          $display("FAIL rand_read[%0d]: addr=%h got %h/%b required %h", n, addr, d, r, exp_rd(idx));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] r, er; logic [NR-1:0] p; bit st, tmo; logic [31:0] d;
    er = model_write(8'h14, 32'h0BAD_F00D, 4'hF);
    do_write(8'h14, 32'h0BAD_F00D, 4'hF, 0, 10, r, p, st, tmo);
    checks++;
    if (tmo || !st || r !== er) begin
      failures++;
      $display("FAIL bp_write: stable=%0d resp=%b tmo=%0d required stable, %b", st, r, tmo, er);
    end
    do_read(8'h14, 10, d, r, st, tmo);
    checks++;
    if (tmo || !st || d !== exp_rd(5)) begin
      failures++;
      $display("FAIL bp_read: stable=%0d got %h required %h", st, d, exp_rd(5));
    end
  endtask

  task automatic test_reset_midop();
    logic [1:0] r, er; logic [NR-1:0] p; bit st, tmo; logic [31:0] d;
    do_write(8'h00, 32'h7777_7777, 4'hF, 0, -1, r, p, st, tmo);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (tmo || bus.bvalid !== 1'b0 || bus.awready !== 1'b0 || wr_pulse !== '0) begin
      failures++;
      $display("FAIL midop_bvalid: bvalid=%b awready=%b tmo=%0d required 0", bus.bvalid, bus.awready, tmo);
    end
    model_reset();
    for (int i = 0; i < NR; i++) begin
      if (i == 1) continue;
      checks++;
      if (reg_out[i*32 +: 32] !== model[i]) begin
        failures++;
        $display("FAIL midop_regs[%0d]: got %h required %h", i, reg_out[i*32 +: 32], model[i]);
      end
    end
    bus.bready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(8'h00, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== 32'hA5A5_0000) begin
      failures++;
      $display("FAIL midop_read0: got %h required a5a50000", d);
    end
    er = model_write(8'h08, 32'h2468_ACE0, 4'hF);
    do_write(8'h08, 32'h2468_ACE0, 4'hF, 1, 0, r, p, st, tmo);
    do_read(8'h08, 0, d, r, st, tmo);
    checks++;
    if (tmo || d !== exp_rd(2)) begin
      failures++;
      $display("FAIL midop_recover: got %h required %h", d, exp_rd(2));
    end
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = 3'b0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = 3'b0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    hw_in = '0; hw_set = '0;
    set_hw1(32'h0000_0000);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_strobe_order();
    test_ro_w1c();
    test_out_of_range();
    test_same_edge();
    test_random();
    test_backpressure();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
